mem_responder: RTL and testbench

- Memory-side responder for the 8-bit multicycle RISC bus. It answers the rd/wr strobes, address and accumulator data that the controller and datapath issue.
- Holds a 32x8 unified instruction/data memory with a configurable wait-state counter.
- Drives the returned data with an output-enable and raises a ready handshake so the initiator can stretch its phases.
- Sits between the address mux/accumulator and the instruction register/ALU operand path.

---
 rtl/risc_pkg.sv | 35 +++
 rtl/mem_responder_mem_array.sv | 26 ++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the 8-bit multicycle RISC bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // Memory responder FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RWAIT = 3'd1,
    RRESP = 3'd2,
    WWAIT = 3'd3,
    WRESP = 3'd4
  } mem_state_t;

  // Instruction opcodes, top three bits of an instruction byte
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Pack an opcode and a 5-bit operand address into one instruction byte
  function automatic logic [7:0] make_instr(opcode_t op, logic [4:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Unified instruction/data storage, 2**ADDR_W x DATA_W, one write port.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; every write strobe is accepted.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset so a preloaded image survives rst_n
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Single synchronous write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: answers rd/wr level requests after WAIT_STATES cycles.
// Latency: read data/ready appear WAIT_STATES+1 edges after the capture edge.
// Backpressure: ready and rdata are held while the initiator holds its request.
// Optional feature: define MEM_PROT_EN to block bus writes below PROT_LIMIT.
module mem_responder #(
  parameter int ADDR_W      = risc_pkg::ADDR_W,
  parameter int DATA_W      = risc_pkg::DATA_W,
  parameter int WAIT_STATES = 1,
  parameter int PROT_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              ready,
  output logic              err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  import risc_pkg::*;

  localparam logic [4:0] WS_V    = 5'(WAIT_STATES);
  localparam bit         WS_ZERO = (WAIT_STATES == 0);

  mem_state_t        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  // Set once the bus has been seen idle; prevents held levels re-triggering
  logic              armed;

  logic              last_wait;
  logic              start_wr;
  logic              start_rd;
  logic              preload;
  logic              wr_commit;
  logic              prot_hit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Request decode and the single write-port mux (FSM commit vs preload)
  always_comb begin
    last_wait   = (({1'b0, cnt} + 5'd1) == WS_V);
    start_wr    = (state == IDLE) && armed && wr;
    start_rd    = (state == IDLE) && armed && !wr && rd;
    preload     = (state == IDLE) && !rd && !wr && ld_we;
    // With zero wait states the commit happens on the capture edge itself
    wr_commit   = (start_wr && WS_ZERO) || ((state == WWAIT) && wr && last_wait);
    commit_addr = (state == IDLE) ? addr  : cap_addr;
    commit_data = (state == IDLE) ? wdata : cap_data;
`ifdef MEM_PROT_EN
    prot_hit    = ({1'b0, commit_addr} < (ADDR_W+1)'(PROT_LIMIT));
`else
    prot_hit    = 1'b0;
`endif
    // Gate with rst_n so a request held through reset never commits
    mem_we      = rst_n && (preload || (wr_commit && !prot_hit));
    mem_waddr   = preload ? ld_addr : commit_addr;
    mem_wdata   = preload ? ld_data : commit_data;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cap_addr),
    .rdata (mem_rdata)
  );

  // Request FSM with registered response outputs and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      armed    <= 1'b1;
      rdata    <= '0;
      rdata_oe <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
`ifdef MEM_PROT_EN
      if (wr_commit && prot_hit) err <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (!rd && !wr) armed <= 1'b1;
          if (start_wr) begin
            cap_addr <= addr;
            cap_data <= wdata;
            cnt      <= '0;
            armed    <= 1'b0;
            if (rd) err <= 1'b1;
            if (WS_ZERO) begin
              state <= WRESP;
              ready <= 1'b1;
            end else begin
              state <= WWAIT;
            end
          end else if (start_rd) begin
            cap_addr <= addr;
            cnt      <= '0;
            armed    <= 1'b0;
            state    <= WS_ZERO ? RRESP : RWAIT;
          end
        end
        RWAIT: begin
          if (!rd) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
            if (last_wait) state <= RRESP;
          end
        end
        RRESP: begin
          if (!rd) begin
            state    <= IDLE;
            rdata    <= '0;
            rdata_oe <= 1'b0;
            ready    <= 1'b0;
          end else begin
            rdata    <= mem_rdata;
            rdata_oe <= 1'b1;
            ready    <= 1'b1;
          end
        end
        WWAIT: begin
          if (!wr) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
            if (last_wait) begin
              state <= WRESP;
              ready <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (!wr) begin
            state <= IDLE;
            ready <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 1 wait state, one with 3.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_mem_responder;

  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ld_we;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       rd1, wr1, rd3, wr3;
  logic [7:0] rdata1, rdata3;
  logic       oe1, oe3, ready1, ready3, err1, err3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd1), .wr(wr1), .wdata(wdata),
    .rdata(rdata1), .rdata_oe(oe1), .ready(ready1), .err(err1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  mem_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd3), .wr(wr3), .wdata(wdata),
    .rdata(rdata3), .rdata_oe(oe3), .ready(ready3), .err(err3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic do_read(input bit sel, input logic [4:0] a, output logic [7:0] d);
    bit seen = 0;
    addr = a;
    if (sel) rd3 = 1'b1; else rd1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel ? ready3 : ready1) begin
        seen = 1;
        break;
      end
    end
    check("read_ready", 32'(seen), 32'd1);
    d = sel ? rdata3 : rdata1;
    rd1 = 1'b0; rd3 = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input bit sel, input logic [4:0] a, input logic [7:0] d);
    bit seen = 0;
    addr = a; wdata = d;
    if (sel) wr3 = 1'b1; else wr1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel ? ready3 : ready1) begin
        seen = 1;
        break;
      end
    end
    check("write_ready", 32'(seen), 32'd1);
    wr1 = 1'b0; wr3 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; addr = '0; wdata = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    tick();
    tick();
    check("rst_rdata", 32'(rdata1), 32'h0);
    check("rst_oe",    32'(oe1),    32'h0);
    check("rst_ready", 32'(ready1), 32'h0);
    check("rst_err",   32'(err1),   32'h0);
    rst_n = 1'b1;
    tick();

    // Preloaded read with 1 wait state: response exactly 2 edges after capture
    preload(5'd3, 8'hA5);
    preload(5'd7, make_instr(STO, 5'd9));
    addr = 5'd3; rd1 = 1'b1;
    tick();
    check("rd_e0_ready", 32'(ready1), 32'h0);
    tick();
    check("rd_e1_ready", 32'(ready1), 32'h0);
    check("rd_e1_oe",    32'(oe1),    32'h0);
    tick();
    check("rd_e2_ready", 32'(ready1), 32'h1);
    check("rd_e2_oe",    32'(oe1),    32'h1);
    check("rd_e2_rdata", 32'(rdata1), 32'hA5);
    addr = 5'd4;
    tick();
    check("rd_hold_rdata", 32'(rdata1), 32'hA5);
    check("rd_hold_ready", 32'(ready1), 32'h1);
    rd1 = 1'b0;
    tick();
    check("rd_drop_ready", 32'(ready1), 32'h0);
    check("rd_drop_oe",    32'(oe1),    32'h0);
    check("rd_drop_rdata", 32'(rdata1), 32'h0);
    tick();
    do_read(1'b0, 5'd7, d);
    check("rd_instr", 32'(d), 32'hC9);

    // Held write commits once on WRESP entry, then reads back
    addr = 5'd20; wdata = 8'h3C; wr1 = 1'b1;
    tick();
    check("wr_e0_ready", 32'(ready1), 32'h0);
    tick();
    check("wr_e1_ready", 32'(ready1), 32'h1);
    check("wr_e1_oe",    32'(oe1),    32'h0);
    tick();
    check("wr_hold_ready", 32'(ready1), 32'h1);
    wr1 = 1'b0;
    tick();
    check("wr_drop_ready", 32'(ready1), 32'h0);
    tick();
    do_read(1'b0, 5'd20, d);
    check("wr_readback", 32'(d), 32'h3C);
    check("wr_err", 32'(err1), 32'h0);

    // rd and wr together: write wins, err goes sticky
    addr = 5'd21; wdata = 8'h77; rd1 = 1'b1; wr1 = 1'b1;
    tick();
    check("both_err", 32'(err1), 32'h1);
    tick();
    check("both_ready", 32'(ready1), 32'h1);
    check("both_oe",    32'(oe1),    32'h0);
    rd1 = 1'b0; wr1 = 1'b0;
    tick();
    tick();
    do_read(1'b0, 5'd21, d);
    check("both_readback", 32'(d), 32'h77);
    check("both_err_sticky", 32'(err1), 32'h1);

    // Three wait states: response 4 edges after capture
    addr = 5'd3; rd3 = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("ws3_e3_ready", 32'(ready3), 32'h0);
    tick();
    check("ws3_e4_ready", 32'(ready3), 32'h1);
    check("ws3_e4_rdata", 32'(rdata3), 32'hA5);
    rd3 = 1'b0;
    tick();
    tick();
    check("ws3_err", 32'(err3), 32'h0);

    // Request dropped during the wait: abort, no ready, err set
    addr = 5'd3; rd3 = 1'b1;
    tick();
    rd3 = 1'b0;
    tick();
    check("abort_ready", 32'(ready3), 32'h0);
    check("abort_err",   32'(err3),   32'h1);
    tick();
    tick();
    check("abort_idle_ready", 32'(ready3), 32'h0);
    check("abort_idle_oe",    32'(oe3),    32'h0);

    // Reset during WWAIT: outputs clear at once and no commit happens
    preload(5'd22, 8'h11);
    addr = 5'd22; wdata = 8'h99; wr3 = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready3), 32'h0);
    check("rst_mid_oe",    32'(oe3),    32'h0);
    check("rst_mid_rdata", 32'(rdata3), 32'h0);
    check("rst_mid_err3",  32'(err3),   32'h0);
    check("rst_mid_err1",  32'(err1),   32'h0);
    wr3 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    do_read(1'b1, 5'd22, d);
    check("rst_mid_mem", 32'(d), 32'h11);
    do_read(1'b0, 5'd3, d);
    check("mem_retained", 32'(d), 32'hA5);

`ifdef MEM_PROT_EN
    // Protected region: write acknowledged but dropped, err set
    preload(5'd5, 8'h12);
    do_write(1'b0, 5'd5, 8'hFF);
    do_read(1'b0, 5'd5, d);
    check("prot_blocked", 32'(d), 32'h12);
    check("prot_err", 32'(err1), 32'h1);
    do_write(1'b0, 5'd16, 8'h42);
    do_read(1'b0, 5'd16, d);
    check("prot_limit_ok", 32'(d), 32'h42);
`else
    do_write(1'b0, 5'd5, 8'hFF);
    do_read(1'b0, 5'd5, d);
    check("unprot_write", 32'(d), 32'hFF);
    check("unprot_err", 32'(err1), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
